// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory req/ack channel,
// and the queue-head outputs feeding the fetch/decode register.
interface fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     stallf;
  logic                     pcsrce;
  logic [ADDRESS_WIDTH-1:0] pctargete;
  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_ack;
  logic [DATA_WIDTH-1:0]    imem_rdata;
  logic [DATA_WIDTH-1:0]    rd;
  logic [ADDRESS_WIDTH-1:0] pcf;
  logic [ADDRESS_WIDTH-1:0] pcplus4f;
  logic                     validf;

  modport master (
    input  stallf, pcsrce, pctargete, imem_ack, imem_rdata,
    output imem_req, imem_addr, rd, pcf, pcplus4f, validf
  );

  modport slave (
    output stallf, pcsrce, pctargete, imem_ack, imem_rdata,
    input  imem_req, imem_addr, rd, pcf, pcplus4f, validf
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, keeps one request outstanding
// to instruction memory and buffers returned instructions in a 2-entry queue.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(3'd4);

  function automatic logic [ADDRESS_WIDTH-1:0] pc_inc(input logic [ADDRESS_WIDTH-1:0] pc);
    return pc + PC_STEP;
  endfunction

  logic [1:0]               state_r;
  logic [1:0]               state_nx_s;
  logic [ADDRESS_WIDTH-1:0] fpc_r;
  logic [ADDRESS_WIDTH-1:0] fpc_nx_s;
  logic [ADDRESS_WIDTH-1:0] tgt_r;
  logic [ADDRESS_WIDTH-1:0] tgt_nx_s;
  logic [DATA_WIDTH-1:0]    q_instr_r [2];
  logic [ADDRESS_WIDTH-1:0] q_pc_r    [2];
  logic                     head_r;
  logic                     head_nx_s;
  logic [1:0]               count_r;
  logic [1:0]               count_nx_s;
  logic                     valid_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     tail_s;

  assign valid_s = (count_r != 2'd0);
  assign pop_s   = valid_s && !bus.stallf && !bus.pcsrce;
  assign push_s  = (state_r == FETCH) && bus.imem_ack && !bus.pcsrce;
  // Tail slot is head+count mod 2; a push is never issued at count 2.
  assign tail_s  = head_r ^ count_r[0];

  // Queue occupancy and head pointer; a redirect flushes everything.
  always_comb begin
    count_nx_s = count_r;
    head_nx_s  = head_r;
    if (bus.pcsrce) begin
      count_nx_s = 2'd0;
      head_nx_s  = 1'b0;
    end else begin
      count_nx_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
      if (pop_s) begin
        head_nx_s = ~head_r;
      end else begin
        head_nx_s = head_r;
      end
    end
  end

  // Fetch FSM: request issue, stale-ack dropping and redirect target tracking.
  always_comb begin
    state_nx_s = state_r;
    fpc_nx_s   = fpc_r;
    tgt_nx_s   = tgt_r;
    case (state_r)
      HOLD: begin
        if (bus.pcsrce) begin
          fpc_nx_s   = bus.pctargete;
          state_nx_s = FETCH;
        end else if (count_nx_s != 2'd2) begin
          state_nx_s = FETCH;
        end else begin
          state_nx_s = HOLD;
        end
      end
      FETCH: begin
        if (bus.pcsrce) begin
          if (bus.imem_ack) begin
            fpc_nx_s   = bus.pctargete;
            state_nx_s = FETCH;
          end else begin
            // The request stays on the bus; its ack is swallowed in DROP.
            tgt_nx_s   = bus.pctargete;
            state_nx_s = DROP;
          end
        end else if (bus.imem_ack) begin
          fpc_nx_s   = pc_inc(fpc_r);
          state_nx_s = (count_nx_s == 2'd2) ? HOLD : FETCH;
        end else begin
          state_nx_s = FETCH;
        end
      end
      DROP: begin
        if (bus.pcsrce) begin
          tgt_nx_s = bus.pctargete;
          if (bus.imem_ack) begin
            fpc_nx_s   = bus.pctargete;
            state_nx_s = FETCH;
          end else begin
            state_nx_s = DROP;
          end
        end else if (bus.imem_ack) begin
          fpc_nx_s   = tgt_r;
          state_nx_s = FETCH;
        end else begin
          state_nx_s = DROP;
        end
      end
      default: begin
        state_nx_s = HOLD;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HOLD;
      fpc_r   <= RESET_PC;
      tgt_r   <= {ADDRESS_WIDTH{1'b0}};
      count_r <= 2'd0;
      head_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      fpc_r   <= fpc_nx_s;
      tgt_r   <= tgt_nx_s;
      count_r <= count_nx_s;
      head_r  <= head_nx_s;
    end
  end

  // Queue storage: returned instruction is written together with the PC it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_instr_r[i] <= {DATA_WIDTH{1'b0}};
        q_pc_r[i]    <= {ADDRESS_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      q_instr_r[tail_s] <= bus.imem_rdata;
      q_pc_r[tail_s]    <= fpc_r;
    end
  end

  assign bus.imem_req  = (state_r != HOLD);
  assign bus.imem_addr = fpc_r;
  assign bus.validf    = valid_s;
  assign bus.rd        = valid_s ? q_instr_r[head_r] : {DATA_WIDTH{1'b0}};
  assign bus.pcf       = valid_s ? q_pc_r[head_r] : {ADDRESS_WIDTH{1'b0}};
  assign bus.pcplus4f  = valid_s ? pc_inc(q_pc_r[head_r]) : {ADDRESS_WIDTH{1'b0}};

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios drive a configurable memory model and
// push expected PCs into a scoreboard drained by an independent output monitor.
module tb_fetch_stage;
  logic clk;
  logic rst_n;

  fetch_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_stage #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int          errors;
  int          checks;
  int          pop_cnt;
  int          lat;
  int          wait_cnt;
  logic        auto_en;
  logic        force_ack;
  logic        saw_200;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: ack after lat wait cycles, or when forced by a scenario.
  always_comb begin
    bus.imem_ack   = bus.imem_req && ((auto_en && (wait_cnt >= lat)) || force_ack);
    bus.imem_rdata = instr_of(bus.imem_addr);
  end

  // Wait-cycle counter of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor / scoreboard.
  initial begin
    logic        prev_ok;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    prev_ok = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.validf) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: got pc %h expected no entry at %0t", bus.pcf, $time);
          end else begin
            check("sb_pcf", bus.pcf, exp_q[0]);
            check("sb_rd", bus.rd, instr_of(exp_q[0]));
            check("sb_pcplus4f", bus.pcplus4f, exp_q[0] + 32'd4);
            if (!bus.stallf && !bus.pcsrce) begin
              void'(exp_q.pop_front());
              pop_cnt++;
            end
          end
        end else begin
          check("bubble_outs", bus.rd | bus.pcf | bus.pcplus4f, 32'h0);
        end
        if (bus.pcsrce) exp_q.delete();
        if (bus.imem_req && bus.imem_ack && bus.imem_addr == 32'h0000_0200) saw_200 = 1'b1;
        if (prev_ok && prev_req && !prev_ack && bus.imem_req)
          check("addr_stable", bus.imem_addr, prev_addr);
        prev_ok   = 1'b1;
        prev_req  = bus.imem_req;
        prev_ack  = bus.imem_ack;
        prev_addr = bus.imem_addr;
      end else begin
        prev_ok = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_reset(input logic st, input int l, input logic aen);
    rst_n         = 1'b0;
    bus.stallf    = st;
    bus.pcsrce    = 1'b0;
    bus.pctargete = 32'h0;
    lat           = l;
    auto_en       = aen;
    force_ack     = 1'b0;
    saw_200       = 1'b0;
    pop_cnt       = 0;
    exp_q.delete();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_req"}, {31'h0, bus.imem_req}, 32'h0);
    check({tag, "_addr"}, bus.imem_addr, 32'h0);
    check({tag, "_rd"}, bus.rd, 32'h0);
    check({tag, "_pcf"}, bus.pcf, 32'h0);
    check({tag, "_pcplus4f"}, bus.pcplus4f, 32'h0);
    check({tag, "_validf"}, {31'h0, bus.validf}, 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Zero-wait streaming after reset.
    hold_reset(1'b0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1 check_zero_outs("reset");
    push_seq(32'h0, 16);
    release_reset();
    cyc(1);
    check("zw_c1_req", {31'h0, bus.imem_req}, 32'h1);
    check("zw_c1_addr", bus.imem_addr, 32'h0);
    check("zw_c1_validf", {31'h0, bus.validf}, 32'h0);
    cyc(1);
    check("zw_c2_validf", {31'h0, bus.validf}, 32'h1);
    check("zw_c2_pcf", bus.pcf, 32'h0);
    check("zw_c2_addr", bus.imem_addr, 32'h4);
    cyc(6);
    check("zw_throughput", 32'(pop_cnt), 32'd6);

    // Slow memory: ack in the 3rd cycle of each request.
    hold_reset(1'b0, 2, 1'b1);
    push_seq(32'h0, 16);
    release_reset();
    cyc(1);
    check("slow_c1_addr", bus.imem_addr, 32'h0);
    cyc(3);
    check("slow_c4_validf", {31'h0, bus.validf}, 32'h1);
    check("slow_c4_pcf", bus.pcf, 32'h0);
    check("slow_c4_addr", bus.imem_addr, 32'h4);
    cyc(1);
    check("slow_c5_bubble", {31'h0, bus.validf}, 32'h0);
    cyc(6);
    check("slow_pops", 32'(pop_cnt), 32'd3);

    // Stall until the queue is full, then release.
    hold_reset(1'b1, 0, 1'b1);
    push_seq(32'h0, 16);
    release_reset();
    cyc(3);
    check("stall_c3_req", {31'h0, bus.imem_req}, 32'h0);
    check("stall_c3_pcf", bus.pcf, 32'h0);
    check("stall_c3_validf", {31'h0, bus.validf}, 32'h1);
    cyc(3);
    check("stall_c6_req", {31'h0, bus.imem_req}, 32'h0);
    check("stall_c6_pcf", bus.pcf, 32'h0);
    check("stall_c6_addr", bus.imem_addr, 32'h8);
    bus.stallf = 1'b0;
    cyc(4);
    check("stall_pops", 32'(pop_cnt), 32'd4);

    // Redirect while a request is pending: stale ack must be dropped.
    hold_reset(1'b1, 0, 1'b1);
    push_seq(32'h0, 16);
    release_reset();
    cyc(3);
    auto_en    = 1'b0;
    bus.stallf = 1'b0;
    cyc(1);
    check("redir_c4_req", {31'h0, bus.imem_req}, 32'h1);
    check("redir_c4_addr", bus.imem_addr, 32'h8);
    check("redir_c4_pcf", bus.pcf, 32'h4);
    bus.pcsrce    = 1'b1;
    bus.pctargete = 32'h0000_0100;
    cyc(1);
    check("redir_flushed", {31'h0, bus.validf}, 32'h0);
    check("redir_drop_addr", bus.imem_addr, 32'h8);
    bus.pcsrce = 1'b0;
    force_ack  = 1'b1;
    push_seq(32'h0000_0100, 16);
    cyc(1);
    force_ack = 1'b0;
    auto_en   = 1'b1;
    check("redir_new_addr", bus.imem_addr, 32'h0000_0100);
    check("redir_no_stale", {31'h0, bus.validf}, 32'h0);
    cyc(5);
    check("redir_pops", 32'(pop_cnt), 32'd5);

    // Two redirects while dropping; the second coincides with the ack.
    hold_reset(1'b0, 0, 1'b0);
    release_reset();
    cyc(1);
    check("dbl_c1_addr", bus.imem_addr, 32'h0);
    bus.pcsrce    = 1'b1;
    bus.pctargete = 32'h0000_0200;
    cyc(1);
    check("dbl_c2_addr", bus.imem_addr, 32'h0);
    bus.pctargete = 32'h0000_0300;
    force_ack     = 1'b1;
    cyc(1);
    bus.pcsrce = 1'b0;
    force_ack  = 1'b0;
    auto_en    = 1'b1;
    check("dbl_next_addr", bus.imem_addr, 32'h0000_0300);
    push_seq(32'h0000_0300, 16);
    cyc(4);
    check("dbl_pops", 32'(pop_cnt), 32'd3);
    check("dbl_no_200", {31'h0, saw_200}, 32'h0);

    // Asynchronous reset in the middle of a request.
    hold_reset(1'b1, 0, 1'b1);
    push_seq(32'h0, 16);
    release_reset();
    cyc(3);
    auto_en    = 1'b0;
    bus.stallf = 1'b0;
    cyc(1);
    check("arst_pre_req", {31'h0, bus.imem_req}, 32'h1);
    check("arst_pre_validf", {31'h0, bus.validf}, 32'h1);
    rst_n = 1'b0;
    #1 check_zero_outs("arst");
    hold_reset(1'b0, 0, 1'b1);
    push_seq(32'h0, 16);
    release_reset();
    cyc(1);
    check("arst_restart_addr", bus.imem_addr, 32'h0);
    check("arst_restart_req", {31'h0, bus.imem_req}, 32'h1);
    cyc(1);
    check("arst_restart_pcf", bus.pcf, 32'h0);
    check("arst_restart_validf", {31'h0, bus.validf}, 32'h1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
